// File: rtl/route_pkg.sv
// Shared types for the waiter-robot drive sequencer.
// State codes 0..8 are decoded directly by motor control.
package route_pkg;

    typedef enum logic [3:0] {
        IDLE_BASE   = 4'd0,
        FORWARDS    = 4'd1,
        TURN        = 4'd2,
        TO_TABLE    = 4'd3,
        IDLE_TABLE  = 4'd4,
        BACKWARDS   = 4'd5,
        TURN_BACK   = 4'd6,
        RETURN_HOME = 4'd7,
        TO_FACE     = 4'd8,
        PAUSE       = 4'd9,
        FAULT       = 4'd10
    } state_t;

    localparam int TIMER_W = 32;

endpackage

// File: rtl/sample_history.sv
// Change-triggered shift register: a sample is stored only when it differs
// from the newest entry. entries[0] is the newest sample.
module sample_history #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [WIDTH-1:0]            sample,
    output logic [DEPTH-1:0][WIDTH-1:0] entries
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            entries <= {DEPTH{RESET_VAL}};
        end else if (sample != entries[0]) begin
            entries[0] <= sample;
            for (int i = 1; i < DEPTH; i++) begin
                entries[i] <= entries[i-1];
            end
        end
    end

endmodule

// File: rtl/route_sequencer_fsm.sv
// Drive sequencer: base -> table -> base with marker-counted table selection,
// obstacle pause/resume and per-leg watchdogs that latch a sticky fault.
module route_sequencer_fsm
    import route_pkg::*;
#(
    parameter int unsigned F_CLK         = 50_000_000,
    parameter int          MIC_DEPTH     = 4,
    parameter int          DIST_DEPTH    = 2,
    parameter logic [7:0]  TOO_CLOSE     = 8'd30,
    parameter int          NUM_TABLES    = 4,
    parameter int unsigned TURN_CYCLES   = 150_000_000,
    parameter int unsigned FACE_CYCLES   = 75_000_000,
    parameter int unsigned MIN_DRIVE     = 50_000_000,
    parameter int unsigned PAUSE_TIMEOUT = 250_000_000,
    parameter int unsigned LEG_TIMEOUT   = 1_000_000_000
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [9:0]                        frequency_input,
    input  logic [4:0]                        threshold_frequency,
    input  logic [7:0]                        distance,
    input  logic [16:0]                       red_pixels,
    input  logic [16:0]                       green_pixels,
    input  logic [16:0]                       blue_pixels,
    input  logic [16:0]                       threshold_pixels,
    input  logic [$clog2(NUM_TABLES+1)-1:0]   table_sel,
    output logic [3:0]                        direction,
    output logic                              fault,
    output logic [$clog2(NUM_TABLES+1)-1:0]   marker_count
);

    localparam int SEL_W = $clog2(NUM_TABLES + 1);
    localparam logic [TIMER_W-1:0] TURN_T  = TIMER_W'(TURN_CYCLES);
    localparam logic [TIMER_W-1:0] FACE_T  = TIMER_W'(FACE_CYCLES);
    localparam logic [TIMER_W-1:0] DRIVE_T = TIMER_W'(MIN_DRIVE);
    localparam logic [TIMER_W-1:0] PAUSE_T = TIMER_W'(PAUSE_TIMEOUT);
    localparam logic [TIMER_W-1:0] LEG_T   = TIMER_W'(LEG_TIMEOUT);

    if (F_CLK == 0 || NUM_TABLES < 1 || MIC_DEPTH < 1 || DIST_DEPTH < 1) begin : g_bad_params
        $error("route_sequencer_fsm: invalid parameter set");
    end

    function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
        return (&t) ? t : t + 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] count_inc(input logic [SEL_W-1:0] c);
        return (c >= SEL_W'(NUM_TABLES)) ? c : c + 1'b1;
    endfunction

    state_t                             state, state_next, ret, ret_next;
    logic [TIMER_W-1:0]                 timer;
    logic [SEL_W-1:0]                   tbl, tbl_next, cnt_next, cnt_inc;
    logic [MIC_DEPTH-1:0][9:0]          mic_hist;
    logic [DIST_DEPTH-1:0][7:0]         dist_hist;
    logic                               threshold_reached, too_close, sel_valid;
    logic                               red_f, green_f, blue_f, blue_f_d1, blue_rise;

    sample_history #(.WIDTH(10), .DEPTH(MIC_DEPTH), .RESET_VAL(10'h000)) u_mic_hist (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (frequency_input),
        .entries (mic_hist)
    );

    sample_history #(.WIDTH(8), .DEPTH(DIST_DEPTH), .RESET_VAL(8'hFF)) u_dist_hist (
        .clk     (clk),
        .reset_n (reset_n),
        .sample  (distance),
        .entries (dist_hist)
    );

    always_comb begin
        threshold_reached = 1'b1;
        for (int i = 0; i < MIC_DEPTH; i++) begin
            if (mic_hist[i] < {5'd0, threshold_frequency}) threshold_reached = 1'b0;
        end
        too_close = 1'b1;
        for (int i = 0; i < DIST_DEPTH; i++) begin
            if (dist_hist[i] > TOO_CLOSE) too_close = 1'b0;
        end
    end

    assign red_f     = red_pixels   > threshold_pixels;
    assign green_f   = green_pixels > threshold_pixels;
    assign blue_f    = blue_pixels  > threshold_pixels;
    assign blue_rise = blue_f & ~blue_f_d1;
    assign sel_valid = (table_sel != '0) && (table_sel <= SEL_W'(NUM_TABLES));
    assign cnt_inc   = count_inc(marker_count);

    always_comb begin
        state_next = state;
        ret_next   = ret;
        tbl_next   = tbl;
        cnt_next   = marker_count;
        case (state)
            IDLE_BASE: if (threshold_reached && sel_valid) begin
                state_next = FORWARDS;
                tbl_next   = table_sel;
                cnt_next   = '0;
            end
            FORWARDS: begin
                if (timer == LEG_T) state_next = FAULT;
                else if (too_close) begin
                    state_next = PAUSE;
                    ret_next   = FORWARDS;
                end else if (blue_rise) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == tbl) state_next = TURN;
                end
            end
            TURN:        if (green_f || timer == TURN_T) state_next = TO_TABLE;
            TO_TABLE: begin
                if (timer == LEG_T) state_next = FAULT;
                else if (red_f || (too_close && timer >= DRIVE_T)) state_next = TO_FACE;
            end
            TO_FACE:     if (timer == FACE_T) state_next = IDLE_TABLE;
            IDLE_TABLE:  if (threshold_reached) state_next = BACKWARDS;
            BACKWARDS: begin
                if (timer == LEG_T) state_next = FAULT;
                else if (too_close) begin
                    state_next = PAUSE;
                    ret_next   = BACKWARDS;
                end else if (green_f) state_next = TURN_BACK;
            end
            TURN_BACK:   if (blue_f || timer == TURN_T) state_next = RETURN_HOME;
            RETURN_HOME: begin
                if (timer == LEG_T) state_next = FAULT;
                else if (too_close || red_f) state_next = IDLE_BASE;
            end
            PAUSE: begin
                if (timer == PAUSE_T) state_next = FAULT;
                else if (!too_close) state_next = ret;
            end
            FAULT:       state_next = FAULT;
            default:     state_next = FAULT;
        endcase
    end

    // State register; the timer restarts whenever the state changes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE_BASE;
            ret          <= FORWARDS;
            tbl          <= '0;
            marker_count <= '0;
            timer        <= '0;
            fault        <= 1'b0;
            blue_f_d1    <= 1'b0;
        end else begin
            state        <= state_next;
            ret          <= ret_next;
            tbl          <= tbl_next;
            marker_count <= cnt_next;
            timer        <= (state_next != state) ? '0 : timer_inc(timer);
            fault        <= (state_next == FAULT);
            blue_f_d1    <= blue_f;
        end
    end

    assign direction = state;

endmodule

// File: tb/tb_route_sequencer_fsm.sv
// Directed bench for route_sequencer_fsm with shortened timing parameters.
module tb_route_sequencer_fsm;

    localparam int S_IDLE_BASE   = 0;
    localparam int S_FORWARDS    = 1;
    localparam int S_TURN        = 2;
    localparam int S_TO_TABLE    = 3;
    localparam int S_IDLE_TABLE  = 4;
    localparam int S_BACKWARDS   = 5;
    localparam int S_TURN_BACK   = 6;
    localparam int S_RETURN_HOME = 7;
    localparam int S_TO_FACE     = 8;
    localparam int S_PAUSE       = 9;
    localparam int S_FAULT       = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  frequency_input;
    logic [4:0]  threshold_frequency;
    logic [7:0]  distance;
    logic [16:0] red_pixels, green_pixels, blue_pixels, threshold_pixels;
    logic [2:0]  table_sel;
    logic [3:0]  direction;
    logic        fault;
    logic [2:0]  marker_count;

    int checks = 0;
    int failures = 0;

    route_sequencer_fsm #(
        .F_CLK(50_000_000), .MIC_DEPTH(4), .DIST_DEPTH(2), .TOO_CLOSE(8'd30),
        .NUM_TABLES(4), .TURN_CYCLES(20), .FACE_CYCLES(10), .MIN_DRIVE(15),
        .PAUSE_TIMEOUT(100), .LEG_TIMEOUT(200)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .frequency_input     (frequency_input),
        .threshold_frequency (threshold_frequency),
        .distance            (distance),
        .red_pixels          (red_pixels),
        .green_pixels        (green_pixels),
        .blue_pixels         (blue_pixels),
        .threshold_pixels    (threshold_pixels),
        .table_sel           (table_sel),
        .direction           (direction),
        .fault               (fault),
        .marker_count        (marker_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_dir(input string tag, input int target, input int budget);
        int n = 0;
        while (int'(direction) != target && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, int'(direction), target);
    endtask

    task automatic mic_trigger(input int base);
        for (int i = 0; i < 4; i++) begin
            frequency_input = 10'(base + i);
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        frequency_input = 10'd0;
        threshold_frequency = 5'd10;
        distance = 8'd200;
        red_pixels = 17'd0;
        green_pixels = 17'd0;
        blue_pixels = 17'd0;
        threshold_pixels = 17'd100;
        table_sel = 3'd0;
        tick(2);
        check_eq("reset_dir", int'(direction), S_IDLE_BASE);
        check_eq("reset_fault", int'(fault), 0);
        check_eq("reset_markers", int'(marker_count), 0);
        reset_n = 1'b1;

        // invalid table selection ignores the mic trigger
        mic_trigger(20);
        tick(5);
        check_eq("sel0_stays_idle", int'(direction), S_IDLE_BASE);

        // valid selection starts the outbound leg
        table_sel = 3'd2;
        wait_dir("start_forwards", S_FORWARDS, 3);
        check_eq("start_markers", int'(marker_count), 0);
        frequency_input = 10'd0;
        tick();

        // first blue marker counts but does not turn
        blue_pixels = 17'd200;
        tick();
        blue_pixels = 17'd0;
        tick();
        check_eq("marker1_count", int'(marker_count), 1);
        check_eq("marker1_dir", int'(direction), S_FORWARDS);

        // obstacle pause and resume
        distance = 8'd20;
        tick();
        distance = 8'd21;
        tick();
        wait_dir("obstacle_pause", S_PAUSE, 3);
        check_eq("pause_markers", int'(marker_count), 1);
        distance = 8'd200;
        wait_dir("resume_forwards", S_FORWARDS, 3);
        check_eq("resume_markers", int'(marker_count), 1);

        // second marker reaches the selected table
        blue_pixels = 17'd200;
        tick();
        blue_pixels = 17'd0;
        check_eq("marker2_turn", int'(direction), S_TURN);
        check_eq("marker2_count", int'(marker_count), 2);

        // turn times out with no green
        tick(20);
        check_eq("turn_before_limit", int'(direction), S_TURN);
        tick();
        check_eq("turn_timeout", int'(direction), S_TO_TABLE);

        // too_close ignored until MIN_DRIVE cycles in TO_TABLE
        distance = 8'd20;
        tick();
        distance = 8'd21;
        tick(4);
        check_eq("early_close_ignored", int'(direction), S_TO_TABLE);
        tick(10);
        check_eq("min_drive_edge", int'(direction), S_TO_TABLE);
        tick();
        check_eq("close_to_face", int'(direction), S_TO_FACE);
        distance = 8'd200;

        tick(10);
        check_eq("face_before_limit", int'(direction), S_TO_FACE);
        tick();
        check_eq("face_done", int'(direction), S_IDLE_TABLE);

        // return trip
        mic_trigger(24);
        wait_dir("mic_backwards", S_BACKWARDS, 3);
        frequency_input = 10'd0;
        green_pixels = 17'd200;
        wait_dir("green_turn_back", S_TURN_BACK, 3);
        green_pixels = 17'd0;
        blue_pixels = 17'd200;
        wait_dir("blue_return_home", S_RETURN_HOME, 3);
        blue_pixels = 17'd0;
        red_pixels = 17'd200;
        wait_dir("red_idle_base", S_IDLE_BASE, 3);
        red_pixels = 17'd0;
        check_eq("trip_no_fault", int'(fault), 0);

        // leg watchdog
        mic_trigger(30);
        wait_dir("wd_forwards", S_FORWARDS, 3);
        frequency_input = 10'd0;
        tick(200);
        check_eq("wd_before_limit", int'(direction), S_FORWARDS);
        tick();
        check_eq("wd_fault_dir", int'(direction), S_FAULT);
        check_eq("wd_fault_flag", int'(fault), 1);
        distance = 8'd20;
        red_pixels = 17'd200;
        tick(10);
        check_eq("fault_sticky", int'(direction), S_FAULT);
        distance = 8'd200;
        red_pixels = 17'd0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("fault_reset_dir", int'(direction), S_IDLE_BASE);
        check_eq("fault_reset_flag", int'(fault), 0);

        // reset mid-route aborts immediately
        table_sel = 3'd1;
        mic_trigger(20);
        wait_dir("abort_forwards", S_FORWARDS, 3);
        frequency_input = 10'd0;
        blue_pixels = 17'd200;
        tick();
        blue_pixels = 17'd0;
        check_eq("abort_turn", int'(direction), S_TURN);
        green_pixels = 17'd200;
        tick();
        green_pixels = 17'd0;
        check_eq("abort_to_table", int'(direction), S_TO_TABLE);
        reset_n = 1'b0;
        tick();
        check_eq("abort_dir", int'(direction), S_IDLE_BASE);
        check_eq("abort_markers", int'(marker_count), 0);
        reset_n = 1'b1;
        tick(3);
        check_eq("abort_stays_idle", int'(direction), S_IDLE_BASE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
